// File: rtl/aerin_arb_pkg.sv
// Shared types and constants for the AERIN round-robin arbiter.
package aerin_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned EVT_CNT_W  = 16;
  localparam int unsigned GRANT_W    = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } arb_state_e;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                 input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/aerin_rr_pick.sv
// Combinational round-robin search: first valid source at or above the pointer, with wrap.
module aerin_rr_pick
  import aerin_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [GRANT_W-1:0] i_ptr,
  input  logic [N_REQ-1:0]   i_valid,
  output logic [N_REQ-1:0]   o_onehot,
  output logic [GRANT_W-1:0] o_idx,
  output logic               o_any
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  int unsigned      v_sum;
  logic [IDX_W-1:0] v_idx;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    v_sum    = 0;
    v_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      v_sum = 32'(i_ptr) + k;
      if (v_sum >= N_REQ) v_sum = v_sum - N_REQ;
      v_idx = IDX_W'(v_sum);
      if (!o_any && i_valid[v_idx]) begin
        o_any           = 1'b1;
        o_onehot[v_idx] = 1'b1;
        o_idx           = GRANT_W'(v_sum);
      end
    end
  end

endmodule

// File: rtl/aerin_arbiter.sv
// Round-robin sharing of the AERIN 4-phase event port between N_REQ sources.
// Optional ACK watchdog enabled by defining AERIN_ARB_TIMEOUT_EN.
module aerin_arbiter
  import aerin_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       AERIN_ADDR,
  output logic                    AERIN_REQ,
  input  logic                    AERIN_ACK,
  output logic                    busy,
  output logic [GRANT_W-1:0]      grant_id,
  output logic [EVT_CNT_W-1:0]    evt_cnt,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic                 r_ack_meta;
  logic                 r_ack_s;
  logic [GRANT_W-1:0]   r_ptr;
  logic [GRANT_W-1:0]   w_ptr_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic                 r_req;
  logic                 w_req_nxt;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   w_grant_nxt;
  logic [EVT_CNT_W-1:0] r_evt_cnt;
  logic [EVT_CNT_W-1:0] w_evt_nxt;
  logic                 r_busy;
  logic                 w_timeout;

  logic [N_REQ-1:0]     w_pick_onehot;
  logic [GRANT_W-1:0]   w_pick_idx;
  logic                 w_pick_any;
  logic [ADDR_W-1:0]    w_addr_arr [N_REQ];
  logic [ADDR_W-1:0]    w_win_addr;

  aerin_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_ptr    (r_ptr),
    .i_valid  (req_valid),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  assign w_win_addr = w_addr_arr[w_pick_idx[IDX_W-1:0]];

  // ACK crosses from the core's domain; the FSM only ever looks at r_ack_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= AERIN_ACK;
      r_ack_s    <= r_ack_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_evt_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_evt_cnt <= w_evt_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_evt_nxt   = r_evt_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_addr_nxt  = w_win_addr;
          w_req_nxt   = 1'b1;
          w_grant_nxt = w_pick_idx;
          w_ptr_nxt   = rr_next(w_pick_idx, N_REQ);
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (r_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!r_ack_s) begin
          w_evt_nxt   = r_evt_cnt + EVT_CNT_W'(1);
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
    // Watchdog abort overrides the handshake and drops the event uncounted.
    if (w_timeout) begin
      w_req_nxt   = 1'b0;
      w_evt_nxt   = r_evt_cnt;
      w_state_nxt = IDLE;
    end
  end

`ifdef AERIN_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = 10;

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_to_err;

  assign w_timeout = (r_state != IDLE) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt != r_state)) begin
      r_wd_cnt <= '0;
    end else if (r_state != IDLE) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Clear wins over a coincident set.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_to_err <= 1'b0;
    end else if (w_timeout) begin
      r_to_err <= 1'b1;
    end
  end

  assign timeout_err = r_to_err;
`else
  logic w_unused;

  assign w_unused    = err_clr | (TIMEOUT_CYCLES == 0);
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign req_ready  = (r_state == IDLE) ? w_pick_onehot : '0;
  assign AERIN_ADDR = r_addr;
  assign AERIN_REQ  = r_req;
  assign busy       = r_busy;
  assign grant_id   = r_grant;
  assign evt_cnt    = r_evt_cnt;

endmodule

// File: tb/tb_aerin_arbiter.sv
// Self-checking bench for aerin_arbiter: randomized sources, delayed-ACK core model.
module tb_aerin_arbiter;

  localparam int unsigned N_REQ          = 2;
  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned TIMEOUT_CYCLES = 1023;

  logic                    clk       = 1'b0;
  logic                    rst       = 1'b1;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr  = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]       AERIN_ADDR;
  logic                    AERIN_REQ;
  logic                    AERIN_ACK = 1'b0;
  logic                    busy;
  logic [1:0]              grant_id;
  logic [15:0]             evt_cnt;
  logic                    timeout_err;
  logic                    err_clr   = 1'b0;

  int checks = 0;
  int errors = 0;

  int         ack_delay = 0;
  bit         ack_stall = 1'b0;
  logic [7:0] req_hist  = '0;
  int         hold_cnt  = 0;

  int          m_ptr   = 0;
  int          t_since = 1000;
  logic [15:0] exp_evt = '0;
  logic [ADDR_W-1:0] src_q [N_REQ][$];
  int                grant_log [$];
  logic [ADDR_W-1:0] addr_log [$];

  aerin_arbiter #(
    .N_REQ          (N_REQ),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .AERIN_ADDR  (AERIN_ADDR),
    .AERIN_REQ   (AERIN_REQ),
    .AERIN_ACK   (AERIN_ACK),
    .busy        (busy),
    .grant_id    (grant_id),
    .evt_cnt     (evt_cnt),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Core model: ACK mirrors REQ delayed by ack_delay negedges; also checks REQ outlives ACK by 3 cycles.
  always @(negedge clk) begin
    req_hist  = {req_hist[6:0], AERIN_REQ};
    AERIN_ACK = ack_stall ? 1'b0 : req_hist[3'(ack_delay)];
    if (AERIN_REQ && AERIN_ACK) begin
      hold_cnt++;
    end else begin
      if (!AERIN_REQ && hold_cnt != 0 && !rst) begin
        checks++;
        if (hold_cnt < 3) begin
          errors++;
          $display("FAIL req_hold got %0d cycles want >=3", hold_cnt);
        end
      end
      hold_cnt = 0;
    end
  end

  function automatic int pick(input int ptr, input logic [N_REQ-1:0] v);
    int idx;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = (ptr + k) % int'(N_REQ);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    m_ptr   = 0;
    exp_evt = '0;
  endtask

  // Drains src_q through the DUT; handshake period is 7 + 2*ack_delay cycles.
  task automatic drive_traffic(input int pct, input int max_cyc);
    int n_target, n_acc, cyc, w, idle_at, exp_id;
    logic [N_REQ-1:0]  exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    bit held [N_REQ];
    n_target = 0;
    for (int i = 0; i < int'(N_REQ); i++) n_target += src_q[i].size();
    n_acc    = 0;
    cyc      = 0;
    exp_id   = 0;
    exp_addr = '0;
    t_since  = 1000;
    held     = '{default: 1'b0};
    idle_at  = 2 * ack_delay + 6;
    while ((n_acc < n_target || t_since < idle_at) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      t_since++;
      if (t_since == 0) begin
        grant_log.push_back(int'(grant_id));
        addr_log.push_back(AERIN_ADDR);
        checks++;
        if (AERIN_REQ !== 1'b1 || AERIN_ADDR !== exp_addr || grant_id !== 2'(exp_id) || busy !== 1'b1) begin
          errors++;
          $display("FAIL accept got req=%b addr=%h id=%0d busy=%b want req=1 addr=%h id=%0d busy=1",
                   AERIN_REQ, AERIN_ADDR, grant_id, busy, exp_addr, exp_id);
        end
      end
      if (t_since == ack_delay + 3) begin
        checks++;
        if (AERIN_REQ !== 1'b0) begin
          errors++;
          $display("FAIL req_fall got %b want 0 at t=%0d", AERIN_REQ, t_since);
        end
      end
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!held[i] && src_q[i].size() > 0 && int'($urandom_range(99)) < pct) held[i] = 1'b1;
        req_valid[i] = held[i];
        req_addr[i*ADDR_W +: ADDR_W] = held[i] ? src_q[i][0] : ADDR_W'($urandom);
      end
      #1;
      w = (t_since >= idle_at) ? pick(m_ptr, req_valid) : -1;
      exp_ready = (w >= 0) ? N_REQ'(1 << w) : '0;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL ready got %b want %b at t=%0d", req_ready, exp_ready, t_since);
      end
      if (w >= 0) begin
        exp_addr = src_q[w].pop_front();
        exp_id   = w;
        held[w]  = 1'b0;
        m_ptr    = (w + 1) % int'(N_REQ);
        t_since  = -1;
        n_acc++;
      end
    end
    req_valid = '0;
    if (cyc >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL traffic_timeout got %0d events want %0d", n_acc, n_target);
    end
    exp_evt = exp_evt + 16'(n_acc);
    checks++;
    if (evt_cnt !== exp_evt || busy !== 1'b0) begin
      errors++;
      $display("FAIL evt_done got cnt=%h busy=%b want cnt=%h busy=0", evt_cnt, busy, exp_evt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (AERIN_REQ !== 1'b0 || AERIN_ADDR !== '0 || grant_id !== 2'd0 || evt_cnt !== 16'd0 ||
        busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset got req=%b addr=%h id=%0d cnt=%h busy=%b terr=%b want all 0",
               AERIN_REQ, AERIN_ADDR, grant_id, evt_cnt, busy, timeout_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    ack_delay = 1;
    src_q[0].push_back(10'h155);
    drive_traffic(100, 200);
    checks++;
    if (evt_cnt !== 16'd1 || AERIN_ADDR !== 10'h155) begin
      errors++;
      $display("FAIL single got cnt=%h addr=%h want cnt=0001 addr=155", evt_cnt, AERIN_ADDR);
    end
    repeat (2) src_q[0].push_back(10'h155);
    drive_traffic(100, 200);
  endtask

  task automatic test_contention();
    int exp_ids [6] = '{0, 1, 0, 1, 0, 1};
    logic [ADDR_W-1:0] exp_addrs [6] = '{10'h001, 10'h202, 10'h001, 10'h202, 10'h001, 10'h202};
    do_reset();
    ack_delay = 0;
    grant_log.delete();
    addr_log.delete();
    repeat (3) begin
      src_q[0].push_back(10'h001);
      src_q[1].push_back(10'h202);
    end
    drive_traffic(100, 300);
    checks++;
    if (grant_log.size() != 6) begin
      errors++;
      $display("FAIL contention_len got %0d want 6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] != exp_ids[i] || addr_log[i] !== exp_addrs[i]) begin
          errors++;
          $display("FAIL contention[%0d] got id=%0d addr=%h want id=%0d addr=%h",
                   i, grant_log[i], addr_log[i], exp_ids[i], exp_addrs[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      ack_delay = int'($urandom_range(3));
      for (int i = 0; i < int'(N_REQ); i++) begin
        repeat ($urandom_range(4, 8)) src_q[i].push_back(ADDR_W'($urandom));
      end
      drive_traffic(40, 3000);
    end
  endtask

  task automatic test_stall();
    int n;
    ack_delay = 0;
    ack_stall = 1'b1;
    @(negedge clk);
    req_addr[0 +: ADDR_W]      = 10'h2AA;
    req_addr[ADDR_W +: ADDR_W] = 10'h133;
    req_valid = 2'b01;
    n = 0;
    while (!AERIN_REQ && n < 10) begin
      @(negedge clk);
      n++;
    end
    m_ptr = 1;
    req_valid = 2'b11;
    checks++;
    if (AERIN_REQ !== 1'b1 || AERIN_ADDR !== 10'h2AA) begin
      errors++;
      $display("FAIL stall_accept got req=%b addr=%h want req=1 addr=2aa", AERIN_REQ, AERIN_ADDR);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (AERIN_REQ !== 1'b1 || req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold got req=%b ready=%b busy=%b want 1 00 1", AERIN_REQ, req_ready, busy);
      end
    end
    req_valid = '0;
`ifdef AERIN_ARB_TIMEOUT_EN
    n = 50;
    while (AERIN_REQ && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 1020 || n > 1030 || timeout_err !== 1'b1 || evt_cnt !== exp_evt || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout got cyc=%0d terr=%b cnt=%h busy=%b want cyc~1024 terr=1 cnt=%h busy=0",
               n, timeout_err, evt_cnt, busy, exp_evt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got %b want 0", timeout_err);
    end
`else
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tied got %b want 0", timeout_err);
    end
    ack_stall = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    exp_evt = exp_evt + 16'd1;
    checks++;
    if (busy !== 1'b0 || evt_cnt !== exp_evt) begin
      errors++;
      $display("FAIL stall_release got busy=%b cnt=%h want busy=0 cnt=%h", busy, evt_cnt, exp_evt);
    end
`endif
    ack_stall = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    ack_stall = 1'b1;
    @(negedge clk);
    req_addr[ADDR_W +: ADDR_W] = 10'h3C3;
    req_valid = 2'b10;
    n = 0;
    while (!AERIN_REQ && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd1 || AERIN_REQ !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got id=%0d req=%b want id=1 req=1", grant_id, AERIN_REQ);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (AERIN_REQ !== 1'b0 || evt_cnt !== 16'd0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid got req=%b cnt=%h busy=%b id=%0d want 0 0000 0 0",
               AERIN_REQ, evt_cnt, busy, grant_id);
    end
    rst       = 1'b0;
    ack_stall = 1'b0;
    m_ptr     = 0;
    exp_evt   = '0;
    repeat (4) @(negedge clk);
    src_q[0].push_back(10'h0F0);
    drive_traffic(100, 100);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_evt_cnt = 16'hFFFF;
    #1;
    release dut.r_evt_cnt;
    exp_evt = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (evt_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h want ffff", evt_cnt);
    end
    ack_delay = int'($urandom_range(2));
    src_q[1].push_back(ADDR_W'($urandom));
    drive_traffic(100, 100);
    checks++;
    if (evt_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap got %h want 0000", evt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_random();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
